// File: rtl/alu_share_arbiter.sv
// Shares one combinational RV64I ALU between two requesters; RV64 *W handling under `ALU_ARB_WORD_OPS_EN`.
// Latency: grant in cycle T, result in the port's response buffer from T+1.
// Backpressure: a port with a full, unaccepted response buffer is not granted; the other port may take every grant.
module alu_share_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_function,
  input  logic [63:0] req0_operand_a,
  input  logic [63:0] req0_operand_b,
  input  logic        req0_word,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_function,
  input  logic [63:0] req1_operand_a,
  input  logic [63:0] req1_operand_b,
  input  logic        req1_word,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_result,
  output logic        rsp0_eq_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_result,
  output logic        rsp1_eq_zero,
  output logic [4:0]  alu_function,
  output logic [63:0] alu_operand_a,
  output logic [63:0] alu_operand_b,
  input  logic [63:0] alu_result
);

  localparam logic [2:0] GRP_ADD_SUB = 3'b000;
  localparam logic [2:0] GRP_SLL     = 3'b001;
  localparam logic [2:0] GRP_SHIFTR  = 3'b101;

  logic        ptr;
  logic        elig0, elig1;
  logic        gnt0, gnt1;
  logic [4:0]  sel_function;
  logic [63:0] sel_a, sel_b;
  logic        sel_word;
  logic [63:0] final_result;

  // A full buffer can be refilled in the same cycle its consumer drains it.
  always_comb begin
    elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!reset) begin
      if (FIXED_PRIORITY != 0 || !ptr) begin
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
      end else begin
        gnt1 = elig1;
        gnt0 = elig0 && !elig1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    sel_function = '0;
    sel_a        = '0;
    sel_b        = '0;
    sel_word     = 1'b0;
    if (gnt0) begin
      sel_function = req0_function;
      sel_a        = req0_operand_a;
      sel_b        = req0_operand_b;
      sel_word     = req0_word;
    end else if (gnt1) begin
      sel_function = req1_function;
      sel_a        = req1_operand_a;
      sel_b        = req1_operand_b;
      sel_word     = req1_word;
    end
  end

`ifdef ALU_ARB_WORD_OPS_EN
  // *W ops reuse the 64-bit ALU: force the 5-bit shamt range, pre-extend the
  // right-shift source so the upper half shifts in correctly, and sign-extend.
  always_comb begin
    alu_function  = sel_function;
    alu_operand_a = sel_a;
    alu_operand_b = sel_b;
    final_result  = alu_result;
    if (sel_word) begin
      case (sel_function[2:0])
        GRP_ADD_SUB: begin
          final_result = {{32{alu_result[31]}}, alu_result[31:0]};
        end
        GRP_SLL: begin
          alu_function[4] = 1'b1;
          final_result    = {{32{alu_result[31]}}, alu_result[31:0]};
        end
        GRP_SHIFTR: begin
          alu_function[4] = 1'b1;
          alu_operand_a   = sel_function[3] ? {{32{sel_a[31]}}, sel_a[31:0]}
                                            : {32'b0, sel_a[31:0]};
          final_result    = {{32{alu_result[31]}}, alu_result[31:0]};
        end
        default: begin
          final_result = alu_result;
        end
      endcase
    end
  end
`else
  logic unused_word;

  assign alu_function  = sel_function;
  assign alu_operand_a = sel_a;
  assign alu_operand_b = sel_b;
  assign final_result  = alu_result;
  assign unused_word   = sel_word;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_result  <= '0;
      rsp0_eq_zero <= 1'b1;
      rsp1_valid   <= 1'b0;
      rsp1_result  <= '0;
      rsp1_eq_zero <= 1'b1;
    end else begin
      if (gnt0) begin
        ptr <= 1'b1;
      end else if (gnt1) begin
        ptr <= 1'b0;
      end

      if (gnt0) begin
        rsp0_valid   <= 1'b1;
        rsp0_result  <= final_result;
        rsp0_eq_zero <= (final_result == 64'd0);
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end

      if (gnt1) begin
        rsp1_valid   <= 1'b1;
        rsp1_result  <= final_result;
        rsp1_eq_zero <= (final_result == 64'd0);
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin and fixed-priority instances, each with its own ALU model.
module tb_alu_share_arbiter;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SUB  = 5'b01000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_SRL  = 5'b00101;
  localparam logic [4:0] F_SRA  = 5'b01101;

`ifdef ALU_ARB_WORD_OPS_EN
  localparam logic [63:0] EXP_SRLW     = 64'h00000000_08000000;
  localparam logic [63:0] EXP_ADDW     = 64'hFFFFFFFF_80000000;
  localparam logic [63:0] EXP_SRAW     = 64'hFFFFFFFF_F8000000;
  localparam logic [63:0] EXP_SRL_OPA  = 64'h00000000_80000000;
  localparam logic [4:0]  EXP_SRL_FUNC = 5'b10101;
`else
  localparam logic [63:0] EXP_SRLW     = 64'h0FFFFFFF_F8000000;
  localparam logic [63:0] EXP_ADDW     = 64'h00000000_80000000;
  localparam logic [63:0] EXP_SRAW     = 64'h00000000_08000000;
  localparam logic [63:0] EXP_SRL_OPA  = 64'hFFFFFFFF_80000000;
  localparam logic [4:0]  EXP_SRL_FUNC = 5'b00101;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_function, req1_function;
  logic [63:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic        req0_word, req1_word;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_result, rsp1_result;
  logic        rsp0_eq_zero, rsp1_eq_zero;
  logic [4:0]  alu_function;
  logic [63:0] alu_operand_a, alu_operand_b, alu_result;

  logic        fp_req0_ready, fp_req1_ready;
  logic        fp_rsp0_valid, fp_rsp1_valid;
  logic [63:0] fp_rsp0_result, fp_rsp1_result;
  logic        fp_rsp0_eq_zero, fp_rsp1_eq_zero;
  logic [4:0]  fp_alu_function;
  logic [63:0] fp_alu_operand_a, fp_alu_operand_b, fp_alu_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [5:0] sh;
    sh = f[4] ? {1'b0, b[4:0]} : b[5:0];
    case (f[2:0])
      3'b000:  alu_f = f[3] ? a - b : a + b;
      3'b001:  alu_f = a << sh;
      3'b010:  alu_f = {63'd0, $signed(a) < $signed(b)};
      3'b011:  alu_f = {63'd0, a < b};
      3'b100:  alu_f = a ^ b;
      3'b101:  alu_f = f[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'b110:  alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_function, alu_operand_a, alu_operand_b);
  assign fp_alu_result = alu_f(fp_alu_function, fp_alu_operand_a, fp_alu_operand_b);

  alu_share_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_function(req0_function),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b), .req0_word(req0_word),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_function(req1_function),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b), .req1_word(req1_word),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_eq_zero(rsp0_eq_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_eq_zero(rsp1_eq_zero),
    .alu_function(alu_function), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result)
  );

  // Fixed-priority instance: both ports request every cycle, consumers always ready.
  alu_share_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(1'b1), .req0_ready(fp_req0_ready), .req0_function(F_ADD),
    .req0_operand_a(64'd1), .req0_operand_b(64'd2), .req0_word(1'b0),
    .req1_valid(1'b1), .req1_ready(fp_req1_ready), .req1_function(F_XOR),
    .req1_operand_a(64'd3), .req1_operand_b(64'd4), .req1_word(1'b0),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(1'b1), .rsp0_result(fp_rsp0_result), .rsp0_eq_zero(fp_rsp0_eq_zero),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(1'b1), .rsp1_result(fp_rsp1_result), .rsp1_eq_zero(fp_rsp1_eq_zero),
    .alu_function(fp_alu_function), .alu_operand_a(fp_alu_operand_a), .alu_operand_b(fp_alu_operand_b),
    .alu_result(fp_alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_function = F_ADD; req0_operand_a = 64'd3; req0_operand_b = 64'd4; req0_word = 1'b0;
    req1_valid = 1'b1; req1_function = F_XOR; req1_operand_a = 64'hF0; req1_operand_b = 64'hFF; req1_word = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, with both ports already requesting.
    tick(); tick(); #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_alu_func", alu_function, 0);
    chk("rst_alu_opa", alu_operand_a, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp0_eqz", rsp0_eq_zero, 1);
    chk("rst_rsp1_eqz", rsp1_eq_zero, 1);

    // Round-robin alternation from port 0.
    reset = 1'b0; #1;
    chk("rr0_req0_ready", req0_ready, 1);
    chk("rr0_req1_ready", req1_ready, 0);
    chk("rr0_alu_opa", alu_operand_a, 3);
    chk("fp0_req0_ready", fp_req0_ready, 1);
    chk("fp0_req1_ready", fp_req1_ready, 0);
    tick(); #1;
    chk("rr1_rsp0_valid", rsp0_valid, 1);
    chk("rr1_rsp0_result", rsp0_result, 7);
    chk("rr1_rsp1_valid", rsp1_valid, 0);
    chk("rr1_req1_ready", req1_ready, 1);
    chk("rr1_req0_ready", req0_ready, 0);
    chk("rr1_alu_func", alu_function, F_XOR);
    chk("fp1_req0_ready", fp_req0_ready, 1);
    chk("fp1_req1_ready", fp_req1_ready, 0);
    tick(); #1;
    chk("rr2_rsp1_valid", rsp1_valid, 1);
    chk("rr2_rsp1_result", rsp1_result, 64'h0F);
    chk("rr2_req0_ready", req0_ready, 1);
    chk("rr2_req1_ready", req1_ready, 0);
    chk("fp2_req1_ready", fp_req1_ready, 0);
    chk("fp2_rsp1_valid", fp_rsp1_valid, 0);
    chk("fp2_rsp0_result", fp_rsp0_result, 3);

    // SUB 5-5 on port 0 -> zero result.
    req0_function = F_SUB; req0_operand_a = 64'd5; req0_operand_b = 64'd5;
    tick(); #1;
    chk("sub_rsp0_result", rsp0_result, 0);
    chk("sub_rsp0_eqz", rsp0_eq_zero, 1);
    chk("sub_rsp0_valid", rsp0_valid, 1);

    // Port 0 stalled for three cycles; port 1 takes every grant.
    rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 1);
      tick();
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_result", rsp0_result, 0);
    end

    // Drain and re-grant in the same cycle.
    rsp0_ready = 1'b1; req0_function = F_ADD; req0_operand_a = 64'd1; req0_operand_b = 64'd1; #1;
    chk("dg_req0_ready", req0_ready, 1);
    chk("dg_req1_ready", req1_ready, 0);
    tick(); #1;
    chk("dg_rsp0_valid", rsp0_valid, 1);
    chk("dg_rsp0_result", rsp0_result, 2);
    chk("dg_rsp0_eqz", rsp0_eq_zero, 0);

    // Drain without grant; result holds.
    req0_valid = 1'b0;
    tick(); #1;
    chk("dr_rsp0_valid", rsp0_valid, 0);
    chk("dr_rsp0_result", rsp0_result, 2);
    req1_valid = 1'b0; #1;
    chk("idle_alu_opa", alu_operand_a, 0);
    chk("idle_alu_opb", alu_operand_b, 0);
    chk("idle_alu_func", alu_function, 0);
    chk("idle_req1_ready", req1_ready, 0);
    tick();

    // Word operations on port 0.
    req0_valid = 1'b1; req0_word = 1'b1;
    req0_function = F_SRL; req0_operand_a = 64'hFFFFFFFF_80000000; req0_operand_b = 64'd4; #1;
    chk("srlw_alu_opa", alu_operand_a, EXP_SRL_OPA);
    chk("srlw_alu_func", alu_function, EXP_SRL_FUNC);
    tick();
    chk("srlw_result", rsp0_result, EXP_SRLW);
    req0_function = F_ADD; req0_operand_a = 64'h7FFFFFFF; req0_operand_b = 64'd1;
    tick();
    chk("addw_result", rsp0_result, EXP_ADDW);
    chk("addw_eqz", rsp0_eq_zero, 0);
    req0_function = F_SRA; req0_operand_a = 64'h80000000; req0_operand_b = 64'd4;
    tick();
    chk("sraw_result", rsp0_result, EXP_SRAW);

    // Fill both buffers, leaving the pointer on port 1, then reset.
    req0_word = 1'b0; req0_function = F_ADD; req0_operand_a = 64'd9; req0_operand_b = 64'd1;
    req1_valid = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    chk("fill_rsp1_valid", rsp1_valid, 1);
    rsp0_ready = 1'b1; #1;
    chk("fill_req0_ready", req0_ready, 1);
    tick();
    rsp0_ready = 1'b0; #1;
    chk("full_rsp0_valid", rsp0_valid, 1);
    chk("full_rsp0_result", rsp0_result, 10);
    chk("full_req0_ready", req0_ready, 0);
    chk("full_req1_ready", req1_ready, 0);
    reset = 1'b1; #1;
    chk("mrst_req0_ready", req0_ready, 0);
    tick();
    chk("mrst_rsp0_valid", rsp0_valid, 0);
    chk("mrst_rsp1_valid", rsp1_valid, 0);
    chk("mrst_rsp0_eqz", rsp0_eq_zero, 1);
    chk("mrst_rsp1_eqz", rsp1_eq_zero, 1);
    reset = 1'b0; #1;
    chk("mrst_first_req0", req0_ready, 1);
    chk("mrst_first_req1", req1_ready, 0);
    tick();
    chk("mrst_rsp0_result", rsp0_result, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
